// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// ALU operations and the datapath mux selects it drives.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL1, S_JAL2, S_JALR1, S_JALR2, S_UTYPE, S_HALT
  } state_t;

  typedef enum logic [1:0] {OPC_ADD, OPC_RTYPE, OPC_ITYPE} op_class_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Funct3/Funct7 to ALU operation for R-type and I-type execute cycles; combinational.
// OPC_ADD forces ADD for address, PC and link arithmetic.
module alu_decoder
  import ctrl_pkg::*;
(
  input  op_class_t   op_class,
  input  logic [2:0]  funct3,
  input  logic        funct7_b5,
  output logic [3:0]  alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    if (op_class != OPC_ADD) begin
      case (funct3)
        // I-type ADDI carries immediate bits in Funct7, so only R-type may subtract
        3'b000:  alu_control = (op_class == OPC_RTYPE && funct7_b5) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_control = ALU_SLL;
        3'b010:  alu_control = ALU_SLT;
        3'b011:  alu_control = ALU_SLTU;
        3'b100:  alu_control = ALU_XOR;
        3'b101:  alu_control = funct7_b5 ? ALU_SRA : ALU_SRL;
        3'b110:  alu_control = ALU_OR;
        default: alu_control = ALU_AND;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I sequencer over one shared memory port; FETCH/MEMRD/MEMWR stall on
// mem_ready (minimum 1 cycle each) and fault-halt after TIMEOUT_CYCLES unanswered cycles.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
)(
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       Opcode,
  input  logic [2:0]       Funct3,
  input  logic [6:0]       Funct7,
  input  logic             br_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [3:0]       ALUControl,
  output logic [2:0]       ImmSrc,
  output logic [1:0]       ResultSrc,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              stall;
  logic              timeout;
  logic              retire;
  logic              is_ebreak;
  op_class_t         op_class;
  logic [3:0]        alu_dec;

  assign stall   = is_wait_state(state) && !mem_ready;
  assign timeout = stall && (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
  assign retire  = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BRANCH) ||
                   (state == S_JAL2) || (state == S_JALR2) || (state == S_MEMWR && mem_ready);
  assign halted  = (state == S_HALT);

  // IR[20] is not routed here, so ECALL/EBREAK (Funct3 = 0, Funct7 = 0) both stop cleanly
  assign is_ebreak = (Funct3 == 3'b000) && (Funct7 == 7'b0000000);

  assign op_class = (state == S_EXECR) ? OPC_RTYPE :
                    (state == S_EXECI) ? OPC_ITYPE : OPC_ADD;

  alu_decoder u_alu_decoder (
    .op_class    (op_class),
    .funct3      (Funct3),
    .funct7_b5   (Funct7[5]),
    .alu_control (alu_dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_FETCH;
      wait_cnt    <= '0;
      fault       <= 1'b0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != S_HALT) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire) instret_cnt <= instret_cnt + CNT_W'(1);
      wait_cnt <= '0;
      if (stall) begin
        if (timeout) begin
          state <= S_HALT;
          fault <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
        end
      end else begin
        case (state)
          S_FETCH:  state <= S_DECODE;
          S_DECODE: begin
            case (Opcode)
              OP_LOAD, OP_STORE: state <= S_MEMADR;
              OP_RTYPE:          state <= S_EXECR;
              OP_ITYPE:          state <= S_EXECI;
              OP_BRANCH:         state <= S_BRANCH;
              OP_JAL:            state <= S_JAL1;
              OP_JALR:           state <= S_JALR1;
              OP_LUI, OP_AUIPC:  state <= S_UTYPE;
              OP_SYSTEM: begin
                state <= S_HALT;
                fault <= !is_ebreak;
              end
              default: begin
                state <= S_HALT;
                fault <= 1'b1;
              end
            endcase
          end
          S_MEMADR: state <= (Opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
          S_MEMRD:  state <= S_MEMWB;
          S_EXECR, S_EXECI, S_UTYPE: state <= S_ALUWB;
          S_JAL1:   state <= S_JAL2;
          S_JALR1:  state <= S_JALR2;
          S_HALT:   state <= S_HALT;
          default:  state <= S_FETCH;
        endcase
      end
    end
  end

  // Strobes are held low while reset is asserted so an in-flight access is dropped at once
  always_comb begin
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ALUControl = ALU_ADD;
    ImmSrc     = IMM_I;
    ResultSrc  = RES_ALUOUT;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_req   = 1'b1;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALU;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
        end
        S_DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = IMM_B;
        end
        S_MEMADR: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = (Opcode == OP_STORE) ? IMM_S : IMM_I;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          AdrSrc  = 1'b1;
        end
        S_MEMWB: begin
          ResultSrc = RES_MEM;
          RegWrite  = 1'b1;
        end
        S_MEMWR: begin
          mem_req  = 1'b1;
          MemWrite = 1'b1;
          AdrSrc   = 1'b1;
        end
        S_EXECR: begin
          ALUSrcA    = SRCA_RS1;
          ALUControl = alu_dec;
        end
        S_EXECI: begin
          ALUSrcA    = SRCA_RS1;
          ALUSrcB    = SRCB_IMM;
          ALUControl = alu_dec;
        end
        S_ALUWB: RegWrite = 1'b1;
        S_BRANCH: begin
          ALUSrcA    = SRCA_RS1;
          ALUControl = ALU_SUB;
          PCWrite    = br_taken;
        end
        S_JAL1, S_JALR1: begin
          ALUSrcA   = SRCA_OLDPC;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALU;
          RegWrite  = 1'b1;
        end
        S_JAL2: begin
          ALUSrcA   = SRCA_OLDPC;
          ALUSrcB   = SRCB_IMM;
          ImmSrc    = IMM_J;
          ResultSrc = RES_ALU;
          PCWrite   = 1'b1;
        end
        S_JALR2: begin
          ALUSrcA   = SRCA_RS1;
          ALUSrcB   = SRCB_IMM;
          ResultSrc = RES_ALU;
          PCWrite   = 1'b1;
        end
        S_UTYPE: begin
          ALUSrcA = (Opcode == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = IMM_U;
        end
        default: ;
      endcase
    end
  end

endmodule
